// File: rtl/nvdla_sdp_dma_pkg.sv
// Shared helpers for the SDP DMA command queue: pointer/count widths,
// occupancy-limit clamp and the push-routing encoding.
package nvdla_sdp_dma_pkg;

  // Where an accepted push lands: straight into the output stage, the
  // prefetch stage, or the storage array behind them.
  typedef enum logic [1:0] {
    PUSH_NONE,
    PUSH_OUT,
    PUSH_MID,
    PUSH_RAM
  } cq_push_dst_e;

  function automatic int unsigned cq_ptr_w(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned cq_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned cq_limit_clamp(input int unsigned limit,
                                                 input int unsigned depth);
    return (limit > depth) ? depth : limit;
  endfunction

endpackage

// File: rtl/nvdla_sdp_dma_cq_ram.sv
// 1W1R storage array for the command queue, registered read with enable.
// Contents are never reset.
module nvdla_sdp_dma_cq_ram
  import nvdla_sdp_dma_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 160,
  parameter int unsigned AW    = cq_ptr_w(DEPTH)
) (
  input  logic             nvdla_core_clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic [31:0]      pwrbus_ram_pd
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Power control is consumed by the hard macro in silicon; nothing to do here.
  logic unused_pwrbus;
  assign unused_pwrbus = ^pwrbus_ram_pd;

  always_ff @(posedge nvdla_core_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/nvdla_sdp_dma_cq.sv
// SDP DMA command queue: first-word-fall-through FIFO built from an output
// register, a prefetch stage and a registered-read RAM, with occupancy limit.
module nvdla_sdp_dma_cq
  import nvdla_sdp_dma_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 160,
  parameter int unsigned CW    = cq_cnt_w(DEPTH)
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             ig2cq_pvld,
  output logic             ig2cq_prdy,
  input  logic [WIDTH-1:0] ig2cq_pd,
  output logic             cq2eg_pvld,
  input  logic             cq2eg_prdy,
  output logic [WIDTH-1:0] cq2eg_pd,
  input  logic             cq_flush,
  input  logic [CW-1:0]    cfg_wr_limit,
  output logic [CW-1:0]    cq_count,
  input  logic [31:0]      pwrbus_ram_pd
);

  localparam int unsigned   AW       = cq_ptr_w(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic             clr;
  logic             push;
  logic             pop;
  logic             out_vld;
  logic [WIDTH-1:0] out_pd;
  logic             mid_vld;
  logic             mid_byp;
  logic [WIDTH-1:0] mid_pd;
  logic [WIDTH-1:0] mid_data;
  logic [WIDTH-1:0] ram_rd_data;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    ram_cnt;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    eff_limit;
  logic             out_free;
  logic             mid_take;
  logic             mid_free;
  logic             rd_en;
  logic             prdy_next;
  logic             ram_wr;
  cq_push_dst_e     push_dst;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  // Ordering is out -> mid -> RAM -> incoming. A push may skip ahead into
  // out or mid only when everything behind that stage is empty, which keeps
  // strict FIFO order while hiding the RAM read latency.
  always_comb begin
    clr      = nvdla_core_rst | cq_flush;
    push     = ig2cq_pvld & ig2cq_prdy;
    pop      = out_vld & cq2eg_prdy;
    out_free = ~out_vld | pop;
    mid_take = out_free & mid_vld;
    mid_free = ~mid_vld | mid_take;
    rd_en    = mid_free & (ram_cnt != '0);
    mid_data = mid_byp ? mid_pd : ram_rd_data;

    push_dst = PUSH_NONE;
    if (push) begin
      if (out_free && !mid_vld && ram_cnt == '0) push_dst = PUSH_OUT;
      else if (mid_free && ram_cnt == '0)        push_dst = PUSH_MID;
      else                                       push_dst = PUSH_RAM;
    end
    ram_wr = (push_dst == PUSH_RAM) & ~clr;

    count_next = clr ? '0 : cq_count + CW'(push) - CW'(pop);
    eff_limit  = CW'(cq_limit_clamp(32'(cfg_wr_limit), DEPTH));
    prdy_next  = !((count_next == CNT_FULL) ||
                   (eff_limit != '0 && count_next >= eff_limit));
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (clr) begin
      out_vld    <= 1'b0;
      mid_vld    <= 1'b0;
      mid_byp    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_cnt    <= '0;
      cq_count   <= '0;
      ig2cq_prdy <= 1'b1;
    end else begin
      cq_count   <= count_next;
      ig2cq_prdy <= prdy_next;
      if (out_free) out_vld <= mid_vld | (push_dst == PUSH_OUT);
      if (mid_free) mid_vld <= rd_en | (push_dst == PUSH_MID);
      if (rd_en)                      mid_byp <= 1'b0;
      else if (push_dst == PUSH_MID)  mid_byp <= 1'b1;
      if (push_dst == PUSH_RAM) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en)                rd_ptr <= ptr_inc(rd_ptr);
      ram_cnt <= ram_cnt + CW'(push_dst == PUSH_RAM) - CW'(rd_en);
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (mid_take)                  out_pd <= mid_data;
    else if (push_dst == PUSH_OUT) out_pd <= ig2cq_pd;
    if (push_dst == PUSH_MID)      mid_pd <= ig2cq_pd;
  end

  assign cq2eg_pvld = out_vld;
  assign cq2eg_pd   = out_pd;

  nvdla_sdp_dma_cq_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .nvdla_core_clk (nvdla_core_clk),
    .wr_en          (ram_wr),
    .wr_addr        (wr_ptr),
    .wr_data        (ig2cq_pd),
    .rd_en          (rd_en & ~clr),
    .rd_addr        (rd_ptr),
    .rd_data        (ram_rd_data),
    .pwrbus_ram_pd  (pwrbus_ram_pd)
  );

endmodule
